// File: rtl/instruction_sequencer.sv
// Fetch-and-issue controller: steps a local program memory into the processor's iin and pulses run.
// Latency: start to first run is 3 cycles; proc_done to next run is 3 cycles (4-cycle minimum issue interval).
// Backpressure: holds iin in WAIT until proc_done; load_en/start are ignored while busy.
module instruction_sequencer #(
    parameter int                 ADDR_W    = 5,
    parameter int                 DATA_W    = 16,
    parameter logic [DATA_W-1:0]  HALT_WORD = 16'hFFFF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              proc_done,
    output logic [DATA_W-1:0] iin,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_HALTED
    } state_t;

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_dat;
    logic              ctl_idle;
    logic              load_ok;
    logic              start_ok;
    logic              is_halt;
    logic              busy_nxt;
    logic              halted_nxt;

    assign ctl_idle = (state == S_IDLE) || (state == S_HALTED);
    assign load_ok  = ctl_idle && load_en;
    assign start_ok = ctl_idle && start && !load_en;
    assign is_halt  = (rd_dat == HALT_WORD);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALTED: if (start_ok) state_nxt = S_FETCH;
            S_FETCH:          state_nxt = S_DECODE;
            S_DECODE:         state_nxt = is_halt ? S_HALTED : S_ISSUE;
            S_ISSUE:          state_nxt = S_WAIT;
            S_WAIT: begin
                if (proc_done) state_nxt = (pc == PC_LAST) ? S_HALTED : S_FETCH;
            end
            default:          state_nxt = S_IDLE;
        endcase
    end

    // busy/halted are registered from the next state so they line up with the state register.
    always_comb begin
        run        = (state == S_ISSUE);
        busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_HALTED);
        halted_nxt = (state_nxt == S_HALTED);
    end

    // Program store is deliberately not reset so a program survives a processor reset.
    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
        rd_dat <= mem[pc];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            iin         <= '0;
            pc          <= '0;
            instr_count <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            halted <= halted_nxt;
            if (start_ok) begin
                pc          <= '0;
                instr_count <= '0;
            end
            if (state == S_DECODE && !is_halt) begin
                iin <= rd_dat;
            end
            if (state == S_WAIT && proc_done) begin
                if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                if (pc != PC_LAST) pc <= pc + ADDR_W'(1);
            end
        end
    end

endmodule
